// File: rtl/cpu_bus_fabric_pkg.sv
// cpu_bus_fabric_pkg: shared FSM states, error read value and sizing helper for the CPU bus fabric.
// Contents: state_t (IDLE/ACTIVE/DONE), ERR_RDATA (all-ones, sliced to DW by users), clog2().
package cpu_bus_fabric_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [63:0] ERR_RDATA = '1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_fabric_if.sv
// cpu_bus_fabric_if: CPU master request/response plus slave fan-out bundle.
// master modport: the CPU and the slave devices around the fabric (drive cpu_* requests, slv_rdata/slv_ack).
// slave  modport: the fabric itself (drives cpu_rdata/ack/err, busy and the registered slv_* outputs).
interface cpu_bus_fabric_if #(
    parameter int AW   = 32,
    parameter int DW   = 16,
    parameter int NSLV = 4
);
    logic               cpu_cyc;
    logic               cpu_write;
    logic [DW/8-1:0]    cpu_be;
    logic [AW-1:0]      cpu_addr;
    logic [DW-1:0]      cpu_wdata;
    logic [DW-1:0]      cpu_rdata;
    logic               cpu_ack;
    logic               cpu_err;
    logic               busy;
    logic [NSLV-1:0]    slv_sel;
    logic               slv_write;
    logic [DW/8-1:0]    slv_be;
    logic [AW-1:0]      slv_addr;
    logic [DW-1:0]      slv_wdata;
    logic [NSLV*DW-1:0] slv_rdata;
    logic [NSLV-1:0]    slv_ack;

    modport master (
        output cpu_cyc, cpu_write, cpu_be, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        input  cpu_rdata, cpu_ack, cpu_err, busy, slv_sel, slv_write, slv_be, slv_addr, slv_wdata
    );

    modport slave (
        input  cpu_cyc, cpu_write, cpu_be, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        output cpu_rdata, cpu_ack, cpu_err, busy, slv_sel, slv_write, slv_be, slv_addr, slv_wdata
    );

endinterface

// File: rtl/cpu_bus_fabric_addr_match.sv
// cpu_bus_fabric_addr_match: combinational base/mask decoder with lowest-index priority.
// Ports: addr (in, AW) byte address; hit (out) any slave matched; sel (out, NSLV) one-hot winner.
module cpu_bus_fabric_addr_match #(
    parameter int                 AW       = 32,
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]   addr,
    output logic            hit,
    output logic [NSLV-1:0] sel
);

    logic [NSLV-1:0] m;

    for (genvar i = 0; i < NSLV; i++) begin : g_cmp
        assign m[i] = (addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW];
    end

    // Isolate the lowest set bit so overlapping ranges resolve to the lowest index.
    assign sel = m & (~m + 1'b1);
    assign hit = |m;

endmodule

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: one CPU master to NSLV memory-mapped slaves with decode, wait-state handshake and error response.
// Ports: clk, rst_n (async active-low); bus (slave modport): cpu_* request/response, busy,
//        registered slv_sel/slv_write/slv_be/slv_addr/slv_wdata, slave slv_rdata/slv_ack inputs.
module cpu_bus_fabric
    import cpu_bus_fabric_pkg::*;
#(
    parameter int                 AW       = 32,
    parameter int                 DW       = 16,
    parameter int                 NSLV     = 4,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
    parameter int                 TIMEOUT  = 255
) (
    input logic             clk,
    input logic             rst_n,
    cpu_bus_fabric_if.slave bus
);

    localparam int            TW     = clog2(TIMEOUT + 1) < 1 ? 1 : clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic            hit, sel_ack, expire, err_q;
    logic [NSLV-1:0] hit_sel;
    logic [DW-1:0]   sel_rdata;

    cpu_bus_fabric_addr_match #(
        .AW      (AW),
        .NSLV    (NSLV),
        .SLV_BASE(SLV_BASE),
        .SLV_MASK(SLV_MASK)
    ) u_match (
        .addr(bus.cpu_addr),
        .hit (hit),
        .sel (hit_sel)
    );

    // Only the selected slave's ack counts; strays from other slaves are masked out.
    assign sel_ack = |(bus.slv_ack & bus.slv_sel);
    assign expire  = TIMEOUT != 0 && timer == T_LAST;
    assign bus.busy = state != IDLE;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++)
            sel_rdata |= bus.slv_sel[i] ? bus.slv_rdata[i*DW +: DW] : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.cpu_cyc ? (hit ? ACTIVE : DONE) : IDLE;
            ACTIVE:  state_nxt = (sel_ack || expire) ? DONE : ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer         <= '0;
            err_q         <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.slv_sel   <= '0;
            bus.slv_write <= 1'b0;
            bus.slv_be    <= '0;
            bus.slv_addr  <= '0;
            bus.slv_wdata <= '0;
        end else begin
            // The response is presented one edge after DONE so ack/err/rdata appear together.
            bus.cpu_ack <= state == DONE;
            bus.cpu_err <= state == DONE && err_q;
            if (state == IDLE && bus.cpu_cyc) begin
                bus.slv_write <= bus.cpu_write;
                bus.slv_be    <= bus.cpu_be;
                bus.slv_addr  <= bus.cpu_addr;
                bus.slv_wdata <= bus.cpu_wdata;
                bus.slv_sel   <= hit_sel;
                timer         <= '0;
                err_q         <= !hit;
                if (!hit) bus.cpu_rdata <= ERR_RDATA[DW-1:0];
            end
            if (state == ACTIVE) begin
                timer <= &timer ? timer : timer + 1'b1;
                if (sel_ack || expire) begin
                    // Ack beats a coinciding timeout.
                    bus.slv_sel   <= '0;
                    err_q         <= !sel_ack;
                    bus.cpu_rdata <= !sel_ack ? ERR_RDATA[DW-1:0] : (bus.slv_write ? '0 : sel_rdata);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb_cpu_bus_fabric: directed bench with a transaction-level timing model and per-cycle compare.
module tb_cpu_bus_fabric;

    localparam int AW = 32, DW = 16, NSLV = 4, TO = 8;
    localparam logic [31:0] BASE_A [4] = '{32'h0001_0000, 32'h0000_4000, 32'h0000_5000, 32'h0001_0000};
    localparam logic [31:0] MASK_A [4] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};
    localparam logic [NSLV*AW-1:0] BASE = {BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]};
    localparam logic [NSLV*AW-1:0] MASK = {MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]};
    localparam logic [15:0] SDAT [4] = '{16'hA5A0, 16'h1234, 16'h2222, 16'h3333};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_bus_fabric_if #(.AW(AW), .DW(DW), .NSLV(NSLV)) bus ();
    cpu_bus_fabric_if #(.AW(AW), .DW(DW), .NSLV(NSLV)) bus0 ();

    cpu_bus_fabric #(.AW(AW), .DW(DW), .NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    cpu_bus_fabric #(.AW(AW), .DW(DW), .NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    int tests = 0, fails = 0;
    int n = 0;
    always @(posedge clk) n <= n + 1;

    // Slave devices: each acks after sw[i] wait cycles of being selected.
    int sw [4];
    int cnt [4];
    logic [3:0] force_ack, ack_v;
    always @(posedge clk) for (int i = 0; i < 4; i++) cnt[i] <= bus.slv_sel[i] ? cnt[i] + 1 : 0;
    always_comb begin
        ack_v = '0;
        for (int i = 0; i < 4; i++) ack_v[i] = bus.slv_sel[i] && cnt[i] == sw[i];
    end
    assign bus.slv_ack   = ack_v | force_ack;
    assign bus.slv_rdata = {SDAT[3], SDAT[2], SDAT[1], SDAT[0]};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if ((a & MASK_A[i]) == BASE_A[i]) r = i;
        return r;
    endfunction

    // Model of the current transaction: start edge, last ACTIVE cycle offset, outcome.
    bit          m_v = 1'b0;
    int          m_e = 0, m_k = 0, m_tgt = -1;
    logic        m_w, m_err;
    logic [31:0] m_a;
    logic [15:0] m_d, m_rd;
    logic [1:0]  m_be;

    task automatic model_set(input logic w, input logic [31:0] a, input logic [15:0] d, input logic [1:0] be);
        int t, wt;
        t  = decode(a);
        wt = t < 0 ? 0 : sw[t];
        m_e = n; m_tgt = t; m_w = w; m_a = a; m_d = d; m_be = be;
        m_err = t < 0 || (TO != 0 && wt > TO - 1);
        m_k   = t < 0 ? -1 : (m_err ? TO - 1 : wt);
        m_rd  = m_err ? 16'hFFFF : (w ? 16'h0000 : SDAT[t]);
        m_v = 1'b1;
    endtask

    int         ck;
    logic       ea, eb;
    logic [3:0] es;
    always @(negedge clk) begin
        ck = n - m_e;
        ea = m_v && ck == m_k + 2;
        eb = m_v && ck >= 0 && ck <= m_k + 1;
        es = (m_v && m_tgt >= 0 && ck >= 0 && ck <= m_k) ? 4'b0001 << m_tgt : 4'b0000;
        chk("cmp_ack", 64'(bus.cpu_ack), 64'(ea));
        chk("cmp_busy", 64'(bus.busy), 64'(eb));
        chk("cmp_sel", 64'(bus.slv_sel), 64'(es));
        chk("cmp_err", 64'(bus.cpu_err), 64'(ea && m_err));
        if (ea) chk("cmp_rdata", 64'(bus.cpu_rdata), 64'(m_rd));
        if (eb) begin
            chk("cmp_slv_addr", 64'(bus.slv_addr), 64'(m_a));
            chk("cmp_slv_wdata", 64'(bus.slv_wdata), 64'(m_d));
            chk("cmp_slv_write", 64'(bus.slv_write), 64'(m_w));
            chk("cmp_slv_be", 64'(bus.slv_be), 64'(m_be));
        end
    end

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [15:0] d, input logic [1:0] be,
                          input bit drop, output int lat, output logic [15:0] rd, output logic er,
                          output logic [3:0] s0, output int ns);
        bus.cpu_write = w; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_be = be; bus.cpu_cyc = 1'b1;
        @(posedge clk); #1;
        model_set(w, a, d, be);
        if (drop) bus.cpu_cyc = 1'b0;
        lat = -1; ns = 0; rd = '0; er = 1'b0; s0 = '0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) s0 = bus.slv_sel;
            if (bus.slv_sel != 0) ns++;
            if (bus.cpu_ack) begin
                lat = n - m_e; rd = bus.cpu_rdata; er = bus.cpu_err;
            end
        end
        bus.cpu_cyc = 1'b0;
        if (lat < 0) chk("ack_seen", 64'(0), 64'(1));
    endtask

    int         lat, ns, hang;
    logic [15:0] rd;
    logic       er;
    logic [3:0] s0;

    initial begin
        rst_n = 1'b0;
        bus.cpu_cyc = 0; bus.cpu_write = 0; bus.cpu_be = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus0.cpu_cyc = 0; bus0.cpu_write = 0; bus0.cpu_be = '0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
        bus0.slv_ack = '0; bus0.slv_rdata = '0;
        sw = '{0, 0, 0, 0}; force_ack = '0;
        #12;
        chk("rst_ack", 64'(bus.cpu_ack), 64'(0));
        chk("rst_err", 64'(bus.cpu_err), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_sel", 64'(bus.slv_sel), 64'(0));
        chk("rst_rdata", 64'(bus.cpu_rdata), 64'(0));
        chk("rst_slv_addr", 64'(bus.slv_addr), 64'(0));
        chk("rst_slv_wdata", 64'(bus.slv_wdata), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // zero-wait read of slave 1
        do_txn(0, 32'h0000_4010, 16'h0, 2'b11, 0, lat, rd, er, s0, ns);
        chk("t1_sel", 64'(s0), 64'(4'b0010));
        chk("t1_lat", 64'(lat), 64'(2));
        chk("t1_rdata", 64'(rd), 64'(16'h1234));
        chk("t1_err", 64'(er), 64'(0));

        // write to slave 2 with 5 wait states
        sw[2] = 5;
        do_txn(1, 32'h0000_5008, 16'hBEEF, 2'b01, 0, lat, rd, er, s0, ns);
        chk("t2_sel", 64'(s0), 64'(4'b0100));
        chk("t2_sel_cycles", 64'(ns), 64'(6));
        chk("t2_lat", 64'(lat), 64'(7));
        chk("t2_err", 64'(er), 64'(0));

        // unmapped read
        do_txn(0, 32'hFFFF_0000, 16'h0, 2'b11, 0, lat, rd, er, s0, ns);
        chk("t3_sel_cycles", 64'(ns), 64'(0));
        chk("t3_lat", 64'(lat), 64'(1));
        chk("t3_err", 64'(er), 64'(1));
        chk("t3_rdata", 64'(rd), 64'(16'hFFFF));

        // slave 3 never acks: timeout after 8 ACTIVE cycles
        sw[3] = 1000;
        do_txn(0, 32'h0001_8000, 16'h0, 2'b11, 0, lat, rd, er, s0, ns);
        chk("t4_sel_cycles", 64'(ns), 64'(8));
        chk("t4_lat", 64'(lat), 64'(9));
        chk("t4_err", 64'(er), 64'(1));
        chk("t4_rdata", 64'(rd), 64'(16'hFFFF));

        // ack in the same cycle the timeout would fire: ack wins
        sw[1] = 7;
        do_txn(0, 32'h0000_4000, 16'h0, 2'b11, 0, lat, rd, er, s0, ns);
        chk("t4_tie_lat", 64'(lat), 64'(9));
        chk("t4_tie_err", 64'(er), 64'(0));
        chk("t4_tie_rdata", 64'(rd), 64'(16'h1234));
        sw[1] = 0;

        // TIMEOUT=0 instance never gives up
        bus0.cpu_addr = 32'h0000_4010; bus0.cpu_cyc = 1'b1;
        @(posedge clk); #1; bus0.cpu_cyc = 1'b0;
        hang = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus0.busy && !bus0.cpu_ack && bus0.slv_sel == 4'b0010) hang++;
        end
        chk("t4_hang", 64'(hang), 64'(300));

        // overlapping slaves 0 and 3 with a stray ack from slave 3
        sw[0] = 2; force_ack = 4'b1000;
        do_txn(0, 32'h0001_0020, 16'h0, 2'b11, 0, lat, rd, er, s0, ns);
        chk("t5_sel", 64'(s0), 64'(4'b0001));
        chk("t5_lat", 64'(lat), 64'(4));
        chk("t5_rdata", 64'(rd), 64'(16'hA5A0));
        chk("t5_err", 64'(er), 64'(0));
        force_ack = '0;

        // cpu_cyc dropped right after the request is taken
        sw[2] = 3;
        do_txn(0, 32'h0000_5000, 16'h0, 2'b11, 1, lat, rd, er, s0, ns);
        chk("drop_lat", 64'(lat), 64'(5));
        chk("drop_rdata", 64'(rd), 64'(16'h2222));

        // reset in the middle of an ACTIVE transaction
        bus.cpu_write = 0; bus.cpu_addr = 32'h0000_5000; bus.cpu_wdata = 16'h0; bus.cpu_be = 2'b11;
        bus.cpu_cyc = 1'b1;
        @(posedge clk); #1;
        model_set(0, 32'h0000_5000, 16'h0, 2'b11);
        @(negedge clk); #2;
        rst_n = 1'b0; m_v = 1'b0; bus.cpu_cyc = 1'b0;
        #1;
        chk("t6_sel", 64'(bus.slv_sel), 64'(0));
        chk("t6_busy", 64'(bus.busy), 64'(0));
        chk("t6_ack", 64'(bus.cpu_ack), 64'(0));
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_txn(0, 32'h0000_4010, 16'h0, 2'b11, 0, lat, rd, er, s0, ns);
        chk("t6_after_lat", 64'(lat), 64'(2));
        chk("t6_after_rdata", 64'(rd), 64'(16'h1234));
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
